// File: rtl/aes_pkg.sv
// Shared AES key-schedule encodings, round counts and the schedule controller state type.
package aes_pkg;

    localparam logic [1:0] ALG_128  = 2'b00;
    localparam logic [1:0] ALG_256  = 2'b01;
    localparam logic [1:0] ALG_192  = 2'b10;
    localparam logic [1:0] ALG_RSVD = 2'b11;

    localparam logic [3:0] NR_128 = 4'd10;
    localparam logic [3:0] NR_256 = 4'd14;
    localparam logic [3:0] NR_192 = 4'd12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_GEN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    function automatic logic [3:0] nr_of(input logic [1:0] alg);
        logic [3:0] n;
        case (alg)
            ALG_128: n = NR_128;
            ALG_256: n = NR_256;
            ALG_192: n = NR_192;
            default: n = 4'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/Invkey_module256.sv
// Combinational inverse key expansion: from the last Nk forward-schedule words,
// returns decryption round key i (forward round key Nr-i).
module Invkey_module256
    import aes_pkg::*;
(
    input  logic [255:0] i_key,
    input  logic [1:0]   i_alg,
    input  logic [3:0]   i_round,
    output logic [127:0] o_key
);

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = '0;
        x   = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) acc = acc ^ x;
            x = xtime(x);
        end
        return acc;
    endfunction

    // a^254 is the field inverse (0 maps to 0), followed by the AES affine map
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] inv;
        logic [7:0] sq;
        inv = 8'h01;
        sq  = gf_mul(a, a);
        for (int k = 1; k < 8; k++) begin
            inv = gf_mul(inv, sq);
            sq  = gf_mul(sq, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] rcon(input int n);
        logic [7:0] x;
        x = 8'h01;
        for (int k = 1; k < 10; k++) begin
            if (k < n) x = xtime(x);
        end
        return x;
    endfunction

    function automatic logic [127:0] inv_round_key(input logic [255:0] key,
                                                    input logic [1:0]   alg,
                                                    input logic [3:0]   round);
        logic [7:0][31:0] kw;
        logic [31:0]      w [60];
        logic [31:0]      t;
        logic [127:0]     rk;
        int               nk;
        int               nr;
        int               tot;
        int               fwd;
        kw  = key;
        nr  = int'(nr_of(alg));
        nk  = (alg == ALG_256) ? 8 : ((alg == ALG_192) ? 6 : 4);
        tot = 4 * (nr + 1);
        rk  = '0;
        for (int j = 0; j < 60; j++) w[6'(j)] = '0;
        for (int m = 0; m < 8; m++) begin
            if (m < nk) w[6'(tot - nk + m)] = kw[3'(7 - m)];
        end
        // Walk the forward recurrence backwards: w[j-Nk] = w[j] ^ f(w[j-1])
        for (int j = 59; j >= 4; j--) begin
            if (j < tot && j >= nk) begin
                t = w[6'(j - 1)];
                if (j % nk == 0)
                    t = sub_word({t[23:0], t[31:24]}) ^ {rcon(j / nk), 24'h0};
                else if (nk == 8 && j % 8 == 4)
                    t = sub_word(t);
                w[6'(j - nk)] = w[6'(j)] ^ t;
            end
        end
        fwd = nr - int'(round);
        if (fwd >= 0)
            rk = {w[6'(4 * fwd)], w[6'(4 * fwd + 1)], w[6'(4 * fwd + 2)], w[6'(4 * fwd + 3)]};
        return rk;
    endfunction

    assign o_key = inv_round_key(i_key, i_alg, i_round);

endmodule

// File: rtl/inv_key_sched_ctrl.sv
// Decryption round-key sequencer: walks Invkey_module256 over rounds 0..Nr on start,
// captures keys into a flop buffer and serves them through a 1-cycle registered read port.
//   state   | meaning
//   IDLE    | no valid schedule (after reset or reserved algorithm)
//   GEN     | writing buf[idx] each cycle, idx 0..Nr
//   DONE    | buffer complete, reads served
module inv_key_sched_ctrl
    import aes_pkg::*;
#(
    parameter int NRK_MAX = 15
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [255:0] key,
    input  logic [1:0]   algorithm,
    output logic         busy,
    output logic         ready,
    output logic         err,
    output logic [3:0]   nr,
    input  logic         rd_en,
    input  logic [3:0]   rd_idx,
    output logic [127:0] rd_key,
    output logic         rd_valid
);

    state_t         r_state;
    state_t         w_state_nxt;
    logic [255:0]   r_key;
    logic [1:0]     r_alg;
    logic [3:0]     r_nr;
    logic [3:0]     r_idx;
    logic           r_err;
    logic           r_rd_valid;
    logic [127:0]   r_rd_key;
    logic [127:0]   r_buf [NRK_MAX];

    logic           w_accept;
    logic           w_reject;
    logic           w_rd_ok;
    logic [127:0]   w_rk;
    logic [127:0]   w_rd_data;

    Invkey_module256 u_invkey (
        .i_key   (r_key),
        .i_alg   (r_alg),
        .i_round (r_idx),
        .o_key   (w_rk)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_reject    = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    if (algorithm == ALG_RSVD) begin
                        w_reject    = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_accept    = 1'b1;
                        w_state_nxt = ST_GEN;
                    end
                end
            end
            ST_GEN: begin
                if (r_idx == r_nr) w_state_nxt = ST_DONE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key <= '0;
            r_alg <= ALG_128;
            r_nr  <= '0;
            r_idx <= '0;
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_key <= key;
            r_alg <= algorithm;
            r_nr  <= nr_of(algorithm);
            r_idx <= '0;
            r_err <= 1'b0;
        end else begin
            if (w_reject)          r_err <= 1'b1;
            if (r_state == ST_GEN) r_idx <= r_idx + 4'd1;
        end
    end

    // Buffer is deliberately unreset; ready gates every path that could expose it
    always_ff @(posedge clk) begin
        if (r_state == ST_GEN) r_buf[r_idx] <= w_rk;
    end

    // A start seen in DONE drops ready on this edge, so the same-cycle read is refused
    assign w_rd_ok = rd_en && (r_state == ST_DONE) && !start && (rd_idx <= r_nr);

    always_comb begin
        w_rd_data = '0;
        if (w_rd_ok) w_rd_data = r_buf[rd_idx];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_valid <= 1'b0;
            r_rd_key   <= '0;
        end else begin
            r_rd_valid <= w_rd_ok;
            r_rd_key   <= w_rd_data;
        end
    end

    assign busy     = (r_state == ST_GEN);
    assign ready    = (r_state == ST_DONE);
    assign err      = r_err;
    assign nr       = r_nr;
    assign rd_key   = r_rd_key;
    assign rd_valid = r_rd_valid;

endmodule
